// File: rtl/alu_op_sequencer_if.sv
// Pin-side bundle between the ALU sequencer and its environment (bus, ALU, consumer).
// master = the sequencer, slave = the off-chip driver / ALU / result consumer.
// Widths must match the parameters of the alu_op_sequencer instance using it.
interface alu_op_sequencer_if #(
    parameter int DATA_W = 8,
    parameter int OP_W   = 4
);
    logic              ena;
    logic [DATA_W-1:0] din;
    logic [OP_W-1:0]   din_op;
    logic              din_strobe;
    logic              res_ack;
    logic              clear_err;
    logic [DATA_W-1:0] alu_a;
    logic [DATA_W-1:0] alu_b;
    logic [OP_W-1:0]   alu_op;
    logic [DATA_W-1:0] alu_y;
    logic [3:0]        alu_flags;
    logic [DATA_W-1:0] res;
    logic [3:0]        res_flags;
    logic              res_valid;
    logic              busy;
    logic              overrun;
    logic [7:0]        op_count;

    modport master (
        input  ena, din, din_op, din_strobe, res_ack, clear_err, alu_y, alu_flags,
        output alu_a, alu_b, alu_op, res, res_flags, res_valid, busy, overrun, op_count
    );

    modport slave (
        output ena, din, din_op, din_strobe, res_ack, clear_err, alu_y, alu_flags,
        input  alu_a, alu_b, alu_op, res, res_flags, res_valid, busy, overrun, op_count
    );
endinterface

// File: rtl/alu_op_sequencer.sv
// Purpose: loads A/opcode then B from a narrow strobed bus, drives a combinational ALU, captures its result.
// Latency: result captured EXEC_CYCLES edges after the B edge (EXEC_CYCLES+1 counting the B edge itself).
// Backpressure: result held with res_valid until res_ack; strobes arriving while not accepting set sticky overrun.
module alu_op_sequencer #(
    parameter int DATA_W      = 8,
    parameter int OP_W        = 4,
    parameter int EXEC_CYCLES = 1     // legal 1..15
) (
    input  logic               clk,
    input  logic               rst_n,
    alu_op_sequencer_if.master ifc
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_LOAD_B = 2'd1,
        S_EXEC   = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    // Settle counter counts down to zero; zero means "capture on this edge".
    localparam logic [3:0] CNT_INIT = 4'(EXEC_CYCLES - 1);

    state_t            state_q, state_d;
    logic              strb_q, strb_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [DATA_W-1:0] alu_a_q, alu_a_d;
    logic [DATA_W-1:0] alu_b_q, alu_b_d;
    logic [OP_W-1:0]   alu_op_q, alu_op_d;
    logic [DATA_W-1:0] res_q, res_d;
    logic [3:0]        res_flags_q, res_flags_d;
    logic              res_valid_q, res_valid_d;
    logic              overrun_q, overrun_d;
    logic [7:0]        op_count_q, op_count_d;

    logic              pulse;
    logic              ovr_set;

    // Next-state and datapath: everything holds unless the tile is enabled.
    always_comb begin
        state_d     = state_q;
        strb_d      = strb_q;
        cnt_d       = cnt_q;
        alu_a_d     = alu_a_q;
        alu_b_d     = alu_b_q;
        alu_op_d    = alu_op_q;
        res_d       = res_q;
        res_flags_d = res_flags_q;
        res_valid_d = res_valid_q;
        overrun_d   = overrun_q;
        op_count_d  = op_count_q;
        pulse       = 1'b0;
        ovr_set     = 1'b0;

        if (ifc.ena) begin
            pulse  = ifc.din_strobe & ~strb_q;
            strb_d = ifc.din_strobe;

            unique case (state_q)
                S_IDLE: begin
                    if (pulse) begin
                        alu_a_d  = ifc.din;
                        alu_op_d = ifc.din_op;
                        state_d  = S_LOAD_B;
                    end
                end
                S_LOAD_B: begin
                    if (pulse) begin
                        alu_b_d = ifc.din;
                        cnt_d   = CNT_INIT;
                        state_d = S_EXEC;
                    end
                end
                S_EXEC: begin
                    ovr_set = pulse;
                    if (cnt_q != 4'd0) begin
                        cnt_d = cnt_q - 4'd1;
                    end else begin
                        res_d       = ifc.alu_y;
                        res_flags_d = ifc.alu_flags;
                        res_valid_d = 1'b1;
                        state_d     = S_DONE;
                    end
                end
                S_DONE: begin
                    if (ifc.res_ack) begin
                        res_valid_d = 1'b0;
                        op_count_d  = op_count_q + 8'd1;
                        // A strobe coinciding with the ack starts the next operation.
                        if (pulse) begin
                            alu_a_d  = ifc.din;
                            alu_op_d = ifc.din_op;
                            state_d  = S_LOAD_B;
                        end else begin
                            state_d  = S_IDLE;
                        end
                    end else begin
                        ovr_set = pulse;
                    end
                end
                default: state_d = S_IDLE;
            endcase

            // A new overrun event takes priority over a simultaneous clear.
            overrun_d = ovr_set | (overrun_q & ~ifc.clear_err);
        end
    end

    // State register; reset discards any operation in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            strb_q      <= 1'b0;
            cnt_q       <= 4'd0;
            alu_a_q     <= '0;
            alu_b_q     <= '0;
            alu_op_q    <= '0;
            res_q       <= '0;
            res_flags_q <= 4'd0;
            res_valid_q <= 1'b0;
            overrun_q   <= 1'b0;
            op_count_q  <= 8'd0;
        end else begin
            state_q     <= state_d;
            strb_q      <= strb_d;
            cnt_q       <= cnt_d;
            alu_a_q     <= alu_a_d;
            alu_b_q     <= alu_b_d;
            alu_op_q    <= alu_op_d;
            res_q       <= res_d;
            res_flags_q <= res_flags_d;
            res_valid_q <= res_valid_d;
            overrun_q   <= overrun_d;
            op_count_q  <= op_count_d;
        end
    end

    assign ifc.alu_a     = alu_a_q;
    assign ifc.alu_b     = alu_b_q;
    assign ifc.alu_op    = alu_op_q;
    assign ifc.res       = res_q;
    assign ifc.res_flags = res_flags_q;
    assign ifc.res_valid = res_valid_q;
    assign ifc.busy      = (state_q != S_IDLE);
    assign ifc.overrun   = overrun_q;
    assign ifc.op_count  = op_count_q;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Bench for alu_op_sequencer: two instances (EXEC_CYCLES=1 and 4) share clock, reset and inputs,
// each driving its own adder ALU stub; expected results come from plain arithmetic and counters.
// Inputs change on the falling edge; outputs are sampled on the falling edge.
module tb_alu_op_sequencer;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       ena = 1'b1;
    logic [7:0] din = 8'h00;
    logic [3:0] din_op = 4'h0;
    logic       strobe = 1'b0;
    logic       ack = 1'b0;
    logic       clr = 1'b0;

    int n_tests = 0;
    int n_fail  = 0;
    int exp_cnt = 0;

    always #5 clk = ~clk;

    alu_op_sequencer_if #(.DATA_W(8), .OP_W(4)) if1 ();
    alu_op_sequencer_if #(.DATA_W(8), .OP_W(4)) if4 ();

    assign if1.ena = ena;    assign if4.ena = ena;
    assign if1.din = din;    assign if4.din = din;
    assign if1.din_op = din_op;      assign if4.din_op = din_op;
    assign if1.din_strobe = strobe;  assign if4.din_strobe = strobe;
    assign if1.res_ack = ack;        assign if4.res_ack = ack;
    assign if1.clear_err = clr;      assign if4.clear_err = clr;

    // ALU stubs: y = a + b, flags = {carry, zero, 0, 0}
    logic [8:0] sum1, sum4;
    assign sum1 = {1'b0, if1.alu_a} + {1'b0, if1.alu_b};
    assign sum4 = {1'b0, if4.alu_a} + {1'b0, if4.alu_b};
    assign if1.alu_y = sum1[7:0];
    assign if4.alu_y = sum4[7:0];
    assign if1.alu_flags = {sum1[8], (sum1[7:0] == 8'h00), 2'b00};
    assign if4.alu_flags = {sum4[8], (sum4[7:0] == 8'h00), 2'b00};

    alu_op_sequencer #(.DATA_W(8), .OP_W(4), .EXEC_CYCLES(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .ifc(if1.master)
    );
    alu_op_sequencer #(.DATA_W(8), .OP_W(4), .EXEC_CYCLES(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .ifc(if4.master)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] sum_of(input logic [7:0] a, input logic [7:0] b);
        return a + b;
    endfunction

    function automatic logic [3:0] flags_of(input logic [7:0] a, input logic [7:0] b);
        logic [8:0] s;
        s = {1'b0, a} + {1'b0, b};
        return {s[8], (s[7:0] == 8'h00), 2'b00};
    endfunction

    task automatic step();
        @(negedge clk);
    endtask

    task automatic check_cleared(input string tag);
        check({tag, " alu_a1"}, if1.alu_a, 0);     check({tag, " alu_a4"}, if4.alu_a, 0);
        check({tag, " alu_b1"}, if1.alu_b, 0);     check({tag, " alu_b4"}, if4.alu_b, 0);
        check({tag, " alu_op1"}, if1.alu_op, 0);   check({tag, " alu_op4"}, if4.alu_op, 0);
        check({tag, " res1"}, if1.res, 0);         check({tag, " res4"}, if4.res, 0);
        check({tag, " flags1"}, if1.res_flags, 0); check({tag, " flags4"}, if4.res_flags, 0);
        check({tag, " rv1"}, if1.res_valid, 0);    check({tag, " rv4"}, if4.res_valid, 0);
        check({tag, " busy1"}, if1.busy, 0);       check({tag, " busy4"}, if4.busy, 0);
        check({tag, " ovr1"}, if1.overrun, 0);     check({tag, " ovr4"}, if4.overrun, 0);
        check({tag, " cnt1"}, if1.op_count, 0);    check({tag, " cnt4"}, if4.op_count, 0);
    endtask

    // One A transfer: strobe high for one cycle, then low for one cycle.
    task automatic load_a(input logic [7:0] a, input logic [3:0] op);
        din = a; din_op = op; strobe = 1'b1;
        step();
        strobe = 1'b0;
        step();
        check("a busy1", if1.busy, 1);     check("a busy4", if4.busy, 1);
        check("a alu_a1", if1.alu_a, a);   check("a alu_a4", if4.alu_a, a);
        check("a alu_op1", if1.alu_op, op); check("a alu_op4", if4.alu_op, op);
    endtask

    // B transfer; returns positioned at the falling edge right after the B edge.
    task automatic b_edge(input logic [7:0] b);
        din = b; strobe = 1'b1;
        step();
        strobe = 1'b0;
        check("b alu_b1", if1.alu_b, b);   check("b alu_b4", if4.alu_b, b);
    endtask

    // k = number of edges after the B edge; res_valid must appear exactly after EXEC_CYCLES of them.
    task automatic wait_result();
        for (int k = 0; k <= 4; k++) begin
            check($sformatf("lat1 k=%0d", k), if1.res_valid, (k >= 1));
            check($sformatf("lat4 k=%0d", k), if4.res_valid, (k >= 4));
            if (k < 4) step();
        end
    endtask

    task automatic ack_result(input logic [7:0] a, input logic [7:0] b);
        check("res1", if1.res, sum_of(a, b));          check("res4", if4.res, sum_of(a, b));
        check("flags1", if1.res_flags, flags_of(a, b)); check("flags4", if4.res_flags, flags_of(a, b));
        check("ovr1", if1.overrun, 0);                 check("ovr4", if4.overrun, 0);
        ack = 1'b1;
        step();
        ack = 1'b0;
        exp_cnt++;
        check("ack rv1", if1.res_valid, 0);   check("ack rv4", if4.res_valid, 0);
        check("ack busy1", if1.busy, 0);      check("ack busy4", if4.busy, 0);
        check("op_count1", if1.op_count, exp_cnt % 256);
        check("op_count4", if4.op_count, exp_cnt % 256);
        check("hold alu_a1", if1.alu_a, a);   check("hold alu_a4", if4.alu_a, a);
    endtask

    task automatic full_op(input logic [7:0] a, input logic [3:0] op, input logic [7:0] b);
        load_a(a, op);
        b_edge(b);
        wait_result();
        ack_result(a, b);
    endtask

    initial begin
        logic [7:0] a, b;
        logic [3:0] op;

        // Reset state
        step(); step();
        check_cleared("reset");
        rst_n = 1'b1;
        step();

        // Basic and carry/zero
        full_op(8'h12, 4'h0, 8'h34);
        full_op(8'hFF, 4'h5, 8'h01);

        // Overrun in EXEC (dut4) / DONE (dut1), clear, overrun in DONE, set-wins
        load_a(8'h20, 4'h2);
        b_edge(8'h03);
        step();                                   // k=1
        strobe = 1'b1; step(); strobe = 1'b0;     // k=2, pulse ignored
        check("ovr exec4", if4.overrun, 1);       check("ovr done1", if1.overrun, 1);
        check("ovr busy4", if4.busy, 1);          check("ovr rv4", if4.res_valid, 0);
        check("ovr res1", if1.res, 8'h23);
        clr = 1'b1; step(); clr = 1'b0;           // k=3
        check("clr ovr1", if1.overrun, 0);        check("clr ovr4", if4.overrun, 0);
        step();                                   // k=4
        check("ovr late rv4", if4.res_valid, 1);
        strobe = 1'b1; step(); strobe = 1'b0;
        check("ovr2 ovr1", if1.overrun, 1);       check("ovr2 ovr4", if4.overrun, 1);
        check("ovr2 res1", if1.res, 8'h23);       check("ovr2 res4", if4.res, 8'h23);
        check("ovr2 rv1", if1.res_valid, 1);      check("ovr2 cnt1", if1.op_count, exp_cnt);
        step();
        clr = 1'b1; strobe = 1'b1; step();
        check("setwin ovr1", if1.overrun, 1);     check("setwin ovr4", if4.overrun, 1);
        step();
        check("clr2 ovr1", if1.overrun, 0);       check("clr2 ovr4", if4.overrun, 0);
        clr = 1'b0; strobe = 1'b0; step();

        // Back-to-back: ack and A strobe together
        din = 8'h05; din_op = 4'h3; strobe = 1'b1; ack = 1'b1;
        step();
        strobe = 1'b0; ack = 1'b0;
        exp_cnt++;
        check("b2b busy1", if1.busy, 1);          check("b2b busy4", if4.busy, 1);
        check("b2b alu_a1", if1.alu_a, 8'h05);    check("b2b alu_a4", if4.alu_a, 8'h05);
        check("b2b alu_op1", if1.alu_op, 4'h3);
        check("b2b rv1", if1.res_valid, 0);       check("b2b rv4", if4.res_valid, 0);
        check("b2b cnt1", if1.op_count, exp_cnt); check("b2b cnt4", if4.op_count, exp_cnt);
        check("b2b ovr1", if1.overrun, 0);        check("b2b ovr4", if4.overrun, 0);
        step();
        b_edge(8'h0A);
        wait_result();
        ack_result(8'h05, 8'h0A);

        // ena=0 during EXEC freezes progress and ignores strobe toggles
        load_a(8'h40, 4'h1);
        b_edge(8'h41);
        ena = 1'b0;
        strobe = 1'b1; step();
        strobe = 1'b0; step();
        strobe = 1'b1; step();
        check("frz rv1", if1.res_valid, 0);       check("frz rv4", if4.res_valid, 0);
        check("frz ovr1", if1.overrun, 0);        check("frz ovr4", if4.overrun, 0);
        check("frz busy1", if1.busy, 1);
        ena = 1'b1; strobe = 1'b0;
        wait_result();
        ack_result(8'h40, 8'h41);

        // Random operations until op_count has wrapped
        while (exp_cnt < 256) begin
            a  = 8'($urandom_range(0, 255));
            b  = 8'($urandom_range(0, 255));
            op = 4'($urandom_range(0, 15));
            full_op(a, op, b);
        end
        check("wrap1", if1.op_count, 8'h00);      check("wrap4", if4.op_count, 8'h00);

        // Reset while in LOAD_B
        load_a(8'h77, 4'h9);
        rst_n = 1'b0;
        #1;
        check_cleared("rst_loadb");
        step();
        rst_n = 1'b1;
        exp_cnt = 0;
        step();
        full_op(8'h80, 4'h4, 8'h80);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
